// File: rtl/xgmii_pkg.sv
// xgmii_pkg: XGMII control characters, tx sequencer states and the terminate-word helper.
package xgmii_pkg;

    localparam logic [7:0] IDLE  = 8'h07;
    localparam logic [7:0] START = 8'hFB;
    localparam logic [7:0] TERM  = 8'hFD;
    localparam logic [7:0] ERROR = 8'hFE;
    localparam logic [7:0] PRE   = 8'h55;
    localparam logic [7:0] SFD   = 8'hD5;

    typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_DATA, ST_TERM, ST_DRAIN} tx_seq_state_t;

    typedef struct packed {
        logic [31:0] txd;
        logic [3:0]  txc;
        logic [7:0]  ipg;
    } term_t;

    // Last-beat word: partial keeps fold /T/ into the word; anything else is a full data word.
    function automatic term_t term_word(input logic [31:0] tdata, input logic [3:0] tkeep);
        return tkeep == 4'b0111 ? term_t'{{TERM, tdata[23:0]}, 4'b1000, 8'd1} :
               tkeep == 4'b0011 ? term_t'{{IDLE, TERM, tdata[15:0]}, 4'b1100, 8'd2} :
               tkeep == 4'b0001 ? term_t'{{IDLE, IDLE, TERM, tdata[7:0]}, 4'b1110, 8'd3} :
                                  term_t'{tdata, 4'b0000, 8'd0};
    endfunction

endpackage

// File: rtl/xgmii_tx_sequencer.sv
// xgmii_tx_sequencer: frames a MAC byte stream into 32-bit XGMII words with /S/ on lane 0
// of a 64-bit block, preamble, /T/ or /E/, and a minimum inter-packet gap.
module xgmii_tx_sequencer
    import xgmii_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4,
    parameter int MIN_IPG    = 12
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [CTRL_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic                  i_xgmii_pause,
    output logic [DATA_WIDTH-1:0] o_xgmii_txd,
    output logic [CTRL_WIDTH-1:0] o_xgmii_txc,
    output logic                  o_underrun
);

    localparam logic [7:0] GAP = 8'(MIN_IPG);

    tx_seq_state_t         state, state_n;
    logic                  half;
    logic [7:0]            ipg, ipg_n, ipg_idle;
    logic [DATA_WIDTH-1:0] txd_n;
    logic [CTRL_WIDTH-1:0] txc_n;
    logic                  und_n;
    term_t                 tw;

    assign s_axis_tready = (state == ST_DATA || state == ST_DRAIN) && !i_xgmii_pause;
    assign tw            = term_word(s_axis_tdata, s_axis_tkeep);
    assign ipg_idle      = ipg >= GAP - 8'd4 ? GAP : ipg + 8'd4;

    always_comb begin
        state_n = state;
        ipg_n   = ipg;
        txd_n   = {4{IDLE}};
        txc_n   = 4'b1111;
        und_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                ipg_n = ipg_idle;
                if (s_axis_tvalid && ipg == GAP && !half) begin
                    txd_n   = {PRE, PRE, PRE, START};
                    txc_n   = 4'b0001;
                    ipg_n   = 8'd0;
                    state_n = ST_PRE;
                end
            end
            ST_PRE: begin
                txd_n   = {SFD, PRE, PRE, PRE};
                txc_n   = 4'b0000;
                state_n = ST_DATA;
            end
            ST_DATA: begin
                if (!s_axis_tvalid) begin
                    txd_n   = {4{ERROR}};
                    und_n   = 1'b1;
                    ipg_n   = 8'd0;
                    state_n = ST_DRAIN;
                end else begin
                    txd_n = s_axis_tlast ? tw.txd : s_axis_tdata;
                    txc_n = s_axis_tlast ? tw.txc : 4'b0000;
                    ipg_n = s_axis_tlast ? tw.ipg : 8'd0;
                    if (s_axis_tlast)
                        state_n = tw.txc == 4'b0000 ? ST_TERM : ST_IDLE;
                end
            end
            ST_TERM: begin
                txd_n   = {IDLE, IDLE, IDLE, TERM};
                ipg_n   = 8'd4;
                state_n = ST_IDLE;
            end
            ST_DRAIN: begin
                ipg_n   = ipg_idle;
                state_n = s_axis_tvalid && s_axis_tlast ? ST_IDLE : ST_DRAIN;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            half        <= 1'b0;
            ipg         <= GAP;
            o_xgmii_txd <= {4{IDLE}};
            o_xgmii_txc <= 4'b1111;
            o_underrun  <= 1'b0;
        end else if (i_xgmii_pause) begin
            o_underrun <= 1'b0;
        end else begin
            state       <= state_n;
            half        <= ~half;
            ipg         <= ipg_n;
            o_xgmii_txd <= txd_n;
            o_xgmii_txc <= txc_n;
            o_underrun  <= und_n;
        end
    end

endmodule

// File: doc/xgmii_tx_sequencer.md
# xgmii_tx_sequencer

Frame sequencer that feeds the 32-bit XGMII input of the 64b/66b encoder from a MAC-side byte stream. It inserts start, preamble/SFD, terminate, idle and error control characters and enforces the minimum inter-packet gap. It aligns every /S/ to lane 0 of a 64-bit block and stalls on the encoder's gearbox pause.

## Interface
- DATA_WIDTH, 32, XGMII data width; only 32 is supported.
- CTRL_WIDTH, 4, XGMII control width; one bit per lane.
- MIN_IPG, 12, minimum count of control bytes after the last data byte before the next /S/.
- i_clk  in  1  sole clock.
- i_reset  in  1  reset, synchronous, active-high.
- s_axis_tdata  in  32  frame bytes; lane 0 = [7:0] is the earliest byte.
- s_axis_tkeep  in  4  byte enables.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tlast  in  1  last beat of the frame.
- s_axis_tready  out  1  beat accepted when tvalid && tready.
- i_xgmii_pause  in  1  encoder pause; when high, the encoder does not take the current word.
- o_xgmii_txd  out  32  XGMII data to the encoder.
- o_xgmii_txc  out  4  XGMII control, 1 = control byte.
- o_underrun  out  1  one-cycle pulse when an underrun error word is loaded.

## Operation
- Outputs are registered. A new word is "loaded" only on cycles with i_xgmii_pause=0.
- When pause=1, o_xgmii_txd/txc hold, the FSM and all counters freeze, and s_axis_tready=0.
- s_axis_tready = (state==DATA || state==DRAIN) && !i_xgmii_pause. It is combinational.
- `half` toggles on every loaded word: 0 means the next word is the first half of a 64b block.
- `ipg` counts control bytes loaded since the last data byte and saturates at MIN_IPG.
- IDLE: loads 0x07070707/1111. If s_axis_tvalid, ipg==MIN_IPG and half==0, it loads /S/ instead: txd 0x555555FB, txc 0001. Next state is PRE.
- PRE: loads 0xD5555555/0000, then goes to DATA.
- DATA, beat accepted:
  - Not last: load tdata/0000.
  - tlast with tkeep 1111: load data, then go to TERM.
  - tlast with tkeep 0111: load {FD,b2,b1,b0}/1000; ipg=1.
  - tlast with tkeep 0011: load {07,FD,b1,b0}/1100; ipg=2.
  - tlast with tkeep 0001: load {07,07,FD,b0}/1110; ipg=3.
  - After any partial tlast, go to IDLE.
- Only non-contiguous or non-tlast partial tkeep values are illegal. Treat them as 1111.
- TERM: loads 0x070707FD/1111, sets ipg=4, then goes to IDLE.
- DATA, tvalid=0 (underrun):
  - Load 0xFEFEFEFE/1111 and pulse o_underrun.
  - Set ipg=0 and go to DRAIN.
- DRAIN:
  - Load idles, each adding 4 to ipg.
  - Accept and discard beats until the tlast beat is accepted, then go to IDLE.
- Idle words in IDLE add 4 to ipg; it saturates.
- No deficit idle count; the gap is rounded up to block alignment.

## Timing
- Reset values:
  - o_xgmii_txd 0x07070707, o_xgmii_txc 1111, o_underrun 0.
  - state IDLE, half 0, ipg MIN_IPG, so the first frame may start immediately.
- Reset mid-frame: the next word is idle, with no /T/ or /E/ emitted.
- Latency:
  - tvalid seen in IDLE → /S/ on the outputs the next unpaused cycle.
  - Beat accepted at cycle N → appears on txd at N+1.
- A pause on the beat-accept cycle blocks acceptance. The beat is retaken on the first unpaused cycle.
- Simultaneous tvalid and blocking conditions (ipg not met or half=1) → idle is loaded and the frame waits.

## Structure
- Shared package xgmii_pkg holds:
  - control constants: IDLE 0x07, START 0xFB, TERM 0xFD, ERROR 0xFE, PRE 0x55, SFD 0xD5;
  - the tx_seq_state_t enum {IDLE, PRE, DATA, TERM, DRAIN};
  - the function term_word(tdata, tkeep) that returns {txd, txc, ipg_init}.
- Single module; no sub-module needed.

## Test plan
- Reset, no traffic → txd 0x07070707, txc 1111 every cycle, tready 0.
- 8-byte frame, back-to-back with a second frame, no pause:
  - Words: 0x555555FB/0001, 0xD5555555/0000, d0, d1, 0x070707FD/1111, then 3 idles.
  - Second /S/ appears at word index 8, which is block-aligned with ipg ≥12.
- 5-byte frame (tkeep 1111 then 0001, byte 0xAA) → last word 0x0707FDAA/1110; next /S/ waits until ipg≥12 and half=0.
- Pause high for 2 cycles during DATA → txd/txc held for those cycles, tready 0, no beat lost or duplicated.
- tvalid drops mid-frame → 0xFEFEFEFE/1111 with o_underrun=1 for one cycle; remaining beats are dropped through tlast; the next frame is properly gapped.
- Reset asserted in DATA → the next output is 0x07070707/1111 and the state is IDLE.
